// File: rtl/seg_scan_pkg.sv
// Shared constants, frame FSM state type and seven-segment glyph decode for seg_scan_rx.
package seg_scan_pkg;

   localparam int unsigned MAX_DIGITS = 6;
   localparam logic [5:0]  SEL_BLANK  = 6'h3F;

   // Active-low glyphs with the decimal point dark (bit 7 = 1).
   localparam logic [7:0] GLYPH_0 = 8'hC0;
   localparam logic [7:0] GLYPH_1 = 8'hF9;
   localparam logic [7:0] GLYPH_2 = 8'hA4;
   localparam logic [7:0] GLYPH_3 = 8'hB0;
   localparam logic [7:0] GLYPH_4 = 8'h99;
   localparam logic [7:0] GLYPH_5 = 8'h92;
   localparam logic [7:0] GLYPH_6 = 8'h82;
   localparam logic [7:0] GLYPH_7 = 8'hF8;
   localparam logic [7:0] GLYPH_8 = 8'h80;
   localparam logic [7:0] GLYPH_9 = 8'h90;
   localparam logic [7:0] GLYPH_A = 8'h88;
   localparam logic [7:0] GLYPH_B = 8'h83;
   localparam logic [7:0] GLYPH_C = 8'hC6;
   localparam logic [7:0] GLYPH_D = 8'hA1;
   localparam logic [7:0] GLYPH_E = 8'h86;
   localparam logic [7:0] GLYPH_F = 8'h8E;

   typedef enum logic [0:0] {StIdle, StCollect} frame_state_e;

   // Returns {ok, value}; the decimal point bit is ignored.
   function automatic logic [4:0] seg_to_hex(input logic [7:0] pattern);
      logic [7:0] p;
      p = {1'b1, pattern[6:0]};
      case (p)
         GLYPH_0: seg_to_hex = {1'b1, 4'h0};
         GLYPH_1: seg_to_hex = {1'b1, 4'h1};
         GLYPH_2: seg_to_hex = {1'b1, 4'h2};
         GLYPH_3: seg_to_hex = {1'b1, 4'h3};
         GLYPH_4: seg_to_hex = {1'b1, 4'h4};
         GLYPH_5: seg_to_hex = {1'b1, 4'h5};
         GLYPH_6: seg_to_hex = {1'b1, 4'h6};
         GLYPH_7: seg_to_hex = {1'b1, 4'h7};
         GLYPH_8: seg_to_hex = {1'b1, 4'h8};
         GLYPH_9: seg_to_hex = {1'b1, 4'h9};
         GLYPH_A: seg_to_hex = {1'b1, 4'hA};
         GLYPH_B: seg_to_hex = {1'b1, 4'hB};
         GLYPH_C: seg_to_hex = {1'b1, 4'hC};
         GLYPH_D: seg_to_hex = {1'b1, 4'hD};
         GLYPH_E: seg_to_hex = {1'b1, 4'hE};
         GLYPH_F: seg_to_hex = {1'b1, 4'hF};
         default: seg_to_hex = 5'h00;
      endcase
   endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational decode of one active-low seven-segment pattern to a hex value.
module seg_hex_dec
   import seg_scan_pkg::*;
(
   input  logic [7:0] pattern,
   output logic [3:0] value,
   output logic       ok
);

   always_comb begin
      {ok, value} = seg_to_hex(pattern);
   end

endmodule

// File: rtl/seg_scan_rx.sv
// Demultiplexes a scanned seven-segment bus into per-digit snapshots, one per complete frame.
// Define SEG_SCAN_RX_HEX_EN to build the per-digit hex decoders; otherwise digit_hex/hex_ok are 0.
module seg_scan_rx
   import seg_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 3,
   parameter int unsigned STABLE_CYCLES  = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5:0]              seg_sel,
   input  logic [7:0]              seg_data,
   input  logic                    clr_err,
   output logic [8*NUM_DIGITS-1:0] digit_raw,
   output logic [4*NUM_DIGITS-1:0] digit_hex,
   output logic [NUM_DIGITS-1:0]   hex_ok,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic                    frame_valid,
   output logic                    seq_err,
   output logic                    sel_err,
   output logic                    link_lost
);

   localparam logic [3:0]  STABLE_LAST = 4'(STABLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);
   localparam logic [2:0]  LAST_DIGIT  = 3'(NUM_DIGITS - 1);
   localparam bit          SINGLE      = (NUM_DIGITS == 1);

   logic [5:0]              s_sel, p_sel, sel_low;
   logic [7:0]              s_data, p_data;
   logic [3:0]              stab_q, stab_d;
   logic [15:0]             tmo_q, tmo_d;
   logic [2:0]              sel_digit, expect_q, expect_d;
   logic                    sel_valid, sel_bad, commit, timeout;
   logic                    shadow_we, pub_q, pub_d, seq_err_d, link_lost_d;
   logic [8*NUM_DIGITS-1:0] shadow_q;
   frame_state_e            state_q, state_d;

   assign sel_low = ~s_sel;

   // Digit k drives seg_sel[5-k] low; only a single low bit in range is a digit.
   always_comb begin
      sel_digit = '0;
      sel_valid = 1'b0;
      sel_bad   = 1'b0;
      for (int k = 0; k < int'(MAX_DIGITS); k++) begin
         if (sel_low[int'(MAX_DIGITS) - 1 - k]) sel_digit = 3'(k);
      end
      if (s_sel != SEL_BLANK) begin
         sel_valid = ((sel_low & (sel_low - 6'd1)) == 6'd0) && (sel_digit <= LAST_DIGIT);
         sel_bad   = !sel_valid;
      end
   end

   always_comb begin
      stab_d = 4'd0;
      if ({s_sel, s_data} == {p_sel, p_data}) begin
         stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
      end
      commit  = sel_valid && (stab_d == STABLE_LAST);
      tmo_d   = commit ? 16'd0 : ((tmo_q == TIMEOUT_MAX) ? tmo_q : tmo_q + 16'd1);
      timeout = !commit && (tmo_q == TIMEOUT_MAX - 16'd1);
      link_lost_d = link_lost;
      if (commit) link_lost_d = 1'b0;
      else if (tmo_d == TIMEOUT_MAX) link_lost_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      expect_d  = expect_q;
      shadow_we = 1'b0;
      pub_d     = 1'b0;
      seq_err_d = 1'b0;
      if (timeout) begin
         state_d = StIdle;
      end else if (commit) begin
         unique case (state_q)
            StIdle: begin
               if (sel_digit == 3'd0) begin
                  shadow_we = 1'b1;
                  if (SINGLE) begin
                     pub_d = 1'b1;
                  end else begin
                     expect_d = 3'd1;
                     state_d  = StCollect;
                  end
               end
            end
            StCollect: begin
               if (sel_digit == expect_q) begin
                  shadow_we = 1'b1;
                  expect_d  = expect_q + 3'd1;
                  if (expect_q == LAST_DIGIT) begin
                     pub_d   = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  seq_err_d = 1'b1;
                  // A fresh digit 0 starts a new frame instead of waiting for the next one.
                  if (sel_digit == 3'd0) begin
                     shadow_we = 1'b1;
                     expect_d  = 3'd1;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_sel  <= SEL_BLANK;
         s_data <= 8'hFF;
         p_sel  <= SEL_BLANK;
         p_data <= 8'hFF;
         stab_q <= 4'd0;
         tmo_q  <= 16'd0;
      end else begin
         s_sel  <= seg_sel;
         s_data <= seg_data;
         p_sel  <= s_sel;
         p_data <= s_data;
         stab_q <= stab_d;
         tmo_q  <= tmo_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         expect_q <= 3'd0;
         pub_q    <= 1'b0;
         shadow_q <= {NUM_DIGITS{8'hFF}};
      end else begin
         state_q  <= state_d;
         expect_q <= expect_d;
         pub_q    <= pub_d;
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (shadow_we && (sel_digit == 3'(k))) shadow_q[8*k +: 8] <= s_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_raw   <= {NUM_DIGITS{8'hFF}};
         frame_valid <= 1'b0;
         seq_err     <= 1'b0;
         sel_err     <= 1'b0;
         link_lost   <= 1'b1;
      end else begin
         if (pub_q) digit_raw <= shadow_q;
         frame_valid <= pub_q;
         seq_err     <= seq_err_d;
         if (sel_bad) sel_err <= 1'b1;
         else if (clr_err) sel_err <= 1'b0;
         link_lost   <= link_lost_d;
      end
   end

   always_comb begin
      dp = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) dp[k] = ~digit_raw[8*k + 7];
   end

`ifdef SEG_SCAN_RX_HEX_EN
   for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_dec
      seg_hex_dec u_dec (
         .pattern (digit_raw[8*k +: 8]),
         .value   (digit_hex[4*k +: 4]),
         .ok      (hex_ok[k])
      );
   end
`else
   assign digit_hex = '0;
   assign hex_ok    = '0;
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: two instances (stable filter 1 and 3) share one bus; a frame-level model predicts outputs.
module tb_seg_scan_rx;

   localparam int unsigned N    = 3;
   localparam int unsigned T    = 8;
   localparam int unsigned ST_A = 1;
   localparam int unsigned ST_B = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [5:0]     seg_sel;
   logic [7:0]     seg_data;
   logic           clr_err;
   logic [8*N-1:0] raw_a, raw_b;
   logic [4*N-1:0] hex_a, hex_b;
   logic [N-1:0]   ok_a, ok_b, dp_a, dp_b;
   logic           fv_a, fv_b, seq_a, seq_b, se_a, se_b, ll_a, ll_b;

   always #5 clk = ~clk;

   seg_scan_rx #(.NUM_DIGITS(N), .STABLE_CYCLES(ST_A), .TIMEOUT_CYCLES(T)) dut_a (
      .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_data(seg_data), .clr_err(clr_err),
      .digit_raw(raw_a), .digit_hex(hex_a), .hex_ok(ok_a), .dp(dp_a),
      .frame_valid(fv_a), .seq_err(seq_a), .sel_err(se_a), .link_lost(ll_a)
   );

   seg_scan_rx #(.NUM_DIGITS(N), .STABLE_CYCLES(ST_B), .TIMEOUT_CYCLES(T)) dut_b (
      .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_data(seg_data), .clr_err(clr_err),
      .digit_raw(raw_b), .digit_hex(hex_b), .hex_ok(ok_b), .dp(dp_b),
      .frame_valid(fv_b), .seq_err(seq_b), .sel_err(se_b), .link_lost(ll_b)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]     glyph [16];
   logic [13:0]    smp;
   int             run;
   logic [8*N-1:0] m_raw [2];
   logic [8*N-1:0] m_pend_raw [2];
   logic           m_pend [2];
   logic           m_fv [2];
   logic           m_seq [2];
   logic           m_se [2];
   logic           m_ll [2];
   int             m_idle [2];
   int             m_cnt [2];
   logic [7:0]     m_col [2][N];

   function automatic int stab(input int u);
      return (u == 0) ? int'(ST_A) : int'(ST_B);
   endfunction

   // -1 blank, -2 illegal, otherwise the digit index.
   function automatic int sel_digit(input logic [5:0] sel);
      int z;
      z = $countones(~sel);
      if (z == 0) return -1;
      if (z != 1) return -2;
      for (int i = 0; i < 6; i++) begin
         if (!sel[i]) return (5 - i < int'(N)) ? 5 - i : -2;
      end
      return -2;
   endfunction

   function automatic logic [4:0] ref_hex(input logic [7:0] p);
      for (int v = 0; v < 16; v++) begin
         if ({1'b1, p[6:0]} == glyph[v]) return {1'b1, 4'(v)};
      end
      return 5'd0;
   endfunction

   function automatic logic [5:0] dsel(input int k);
      logic [5:0] one;
      one = 6'h20;
      return ~(one >> k);
   endfunction

   task automatic model_reset();
      smp = {6'h3F, 8'hFF};
      run = 2;
      for (int u = 0; u < 2; u++) begin
         m_raw[u]  = {N{8'hFF}};
         m_pend[u] = 1'b0;
         m_fv[u]   = 1'b0;
         m_seq[u]  = 1'b0;
         m_se[u]   = 1'b0;
         m_ll[u]   = 1'b1;
         m_idle[u] = 0;
         m_cnt[u]  = 0;
      end
   endtask

   // One clock edge: smp is the bus value registered at the previous edge, run its length.
   task automatic model_edge(input int u, input logic clr);
      int d;
      m_fv[u] = m_pend[u];
      if (m_pend[u]) m_raw[u] = m_pend_raw[u];
      m_pend[u] = 1'b0;
      m_seq[u]  = 1'b0;
      d = sel_digit(smp[13:8]);
      if (d >= 0 && run == stab(u)) begin
         m_idle[u] = 0;
         m_ll[u]   = 1'b0;
         if (d == m_cnt[u]) begin
            m_col[u][d] = smp[7:0];
            m_cnt[u]++;
         end else if (m_cnt[u] != 0) begin
            m_seq[u] = 1'b1;
            m_cnt[u] = 0;
            if (d == 0) begin
               m_col[u][0] = smp[7:0];
               m_cnt[u]    = 1;
            end
         end
         if (m_cnt[u] == int'(N)) begin
            for (int k = 0; k < int'(N); k++) m_pend_raw[u][8*k +: 8] = m_col[u][k];
            m_pend[u] = 1'b1;
            m_cnt[u]  = 0;
         end
      end else begin
         if (m_idle[u] < int'(T)) m_idle[u]++;
         if (m_idle[u] == int'(T)) begin
            m_ll[u]  = 1'b1;
            m_cnt[u] = 0;
         end
      end
      if (d == -2) m_se[u] = 1'b1;
      else if (clr) m_se[u] = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int u, input string ph, input logic [8*N-1:0] raw,
                            input logic [4*N-1:0] hex, input logic [N-1:0] ok,
                            input logic [N-1:0] dpv, input logic fv, input logic seq,
                            input logic se, input logic ll);
      logic [4*N-1:0] e_hex;
      logic [N-1:0]   e_ok, e_dp;
      logic [4:0]     h;
      string          p;
      p = $sformatf("%s.%s", ph, (u == 0) ? "a" : "b");
      for (int k = 0; k < int'(N); k++) begin
         h = ref_hex(m_raw[u][8*k +: 8]);
         e_hex[4*k +: 4] = h[3:0];
         e_ok[k] = h[4];
         e_dp[k] = ~m_raw[u][8*k + 7];
      end
`ifndef SEG_SCAN_RX_HEX_EN
      e_hex = '0;
      e_ok  = '0;
`endif
      chk({p, ".raw"}, 32'(raw), 32'(m_raw[u]));
      chk({p, ".hex"}, 32'(hex), 32'(e_hex));
      chk({p, ".hex_ok"}, 32'(ok), 32'(e_ok));
      chk({p, ".dp"}, 32'(dpv), 32'(e_dp));
      chk({p, ".frame_valid"}, 32'(fv), 32'(m_fv[u]));
      chk({p, ".seq_err"}, 32'(seq), 32'(m_seq[u]));
      chk({p, ".sel_err"}, 32'(se), 32'(m_se[u]));
      chk({p, ".link_lost"}, 32'(ll), 32'(m_ll[u]));
   endtask

   task automatic check_both(input string ph);
      check_dut(0, ph, raw_a, hex_a, ok_a, dp_a, fv_a, seq_a, se_a, ll_a);
      check_dut(1, ph, raw_b, hex_b, ok_b, dp_b, fv_b, seq_b, se_b, ll_b);
   endtask

   task automatic cycle(input logic [5:0] sel, input logic [7:0] data, input logic clr,
                        input string ph);
      seg_sel  = sel;
      seg_data = data;
      clr_err  = clr;
      @(posedge clk);
      model_edge(0, clr);
      model_edge(1, clr);
      run = ({sel, data} == smp) ? run + 1 : 1;
      smp = {sel, data};
      #1;
      check_both(ph);
   endtask

   task automatic scan(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input int frames, input int hold, input string ph);
      for (int f = 0; f < frames; f++) begin
         repeat (hold) cycle(dsel(0), d0, 1'b0, ph);
         repeat (hold) cycle(dsel(1), d1, 1'b0, ph);
         repeat (hold) cycle(dsel(2), d2, 1'b0, ph);
      end
   endtask

   initial begin
      int cur;
      glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      rst      = 1'b1;
      seg_sel  = 6'h3F;
      seg_data = 8'hFF;
      clr_err  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_both("reset");
      rst = 1'b0;

      scan(8'hC0, 8'hF9, 8'hA4, 4, 1, "scan");
      chk("scan.raw_const", 32'(raw_a), 32'h00A4F9C0);
`ifdef SEG_SCAN_RX_HEX_EN
      chk("scan.hex_const", 32'(hex_a), 32'h210);
      chk("scan.ok_const", 32'(ok_a), 32'h7);
`endif
      scan(8'hC0, 8'h79, 8'hA4, 2, 1, "dp");
      chk("dp.dp_const", 32'(dp_a), 32'h2);
      scan(8'hC0, 8'hF9, 8'hFF, 2, 1, "blankglyph");

      // Out-of-order: 0, 2, 1.
      cycle(dsel(0), 8'h99, 1'b0, "order");
      cycle(dsel(2), 8'h92, 1'b0, "order");
      cycle(dsel(1), 8'h82, 1'b0, "order");
      repeat (3) cycle(6'h3F, 8'hFF, 1'b0, "order");

      cycle(6'h0F, 8'hC0, 1'b0, "selerr");
      repeat (3) cycle(6'h3F, 8'hFF, 1'b0, "selerr");
      chk("selerr.sticky", 32'(se_a), 32'h1);
      cycle(6'h3F, 8'hFF, 1'b1, "clr");
      repeat (2) cycle(6'h3F, 8'hFF, 1'b0, "clr");
      cycle(6'h3B, 8'hC0, 1'b0, "range");
      cycle(6'h3F, 8'hFF, 1'b1, "range");
      cycle(6'h3F, 8'hFF, 1'b1, "range");

      scan(8'hB0, 8'h99, 8'h92, 1, 1, "tmo");
      repeat (10) cycle(6'h3F, 8'hFF, 1'b0, "tmo");
      chk("tmo.ll_const", 32'(ll_a), 32'h1);
      scan(8'h88, 8'h83, 8'hC6, 1, 1, "relink");

      scan(8'hA1, 8'h86, 8'h8E, 2, 2, "hold2");
      scan(8'h80, 8'h90, 8'hF8, 3, 3, "hold3");

      cur = 2;
      for (int i = 0; i < 120; i++) begin
         int         r;
         int         hold;
         logic [5:0] s;
         logic [7:0] d;
         logic       c;
         r    = $urandom_range(0, 9);
         hold = $urandom_range(1, 4);
         if (r <= 5) begin
            cur = (cur + 1) % 3;
            s   = dsel(cur);
         end else if (r == 6) s = dsel($urandom_range(0, 2));
         else if (r == 7) s = 6'h3F;
         else if (r == 8) s = 6'($urandom);
         else s = dsel($urandom_range(3, 5));
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : glyph[$urandom_range(0, 15)];
         c = ($urandom_range(0, 15) == 0);
         repeat (hold) cycle(s, d, c, "rand");
      end

      scan(8'hC0, 8'hF9, 8'hA4, 2, 3, "prerst");
      cycle(dsel(0), 8'h86, 1'b0, "midrst");
      repeat (3) cycle(dsel(1), 8'h8E, 1'b0, "midrst");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_both("midrst");
      @(posedge clk);
      #1 rst = 1'b0;
      scan(8'hF9, 8'hA4, 8'hB0, 2, 3, "postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
